// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder_if
// Description : Request/response bus between an initiator and the data memory.
// Revision    : 1.0
// ============================================================================
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic [3:0]  req_write_mask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic        write_done;

    modport master (
        output req_valid, req_write, req_address, req_write_data, req_write_mask, resp_ready,
        input  req_ready, resp_valid, resp_read_data, resp_error, write_done
    );

    modport slave (
        input  req_valid, req_write, req_address, req_write_data, req_write_mask, resp_ready,
        output req_ready, resp_valid, resp_read_data, resp_error, write_done
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder
// Description : Word memory with byte-masked stores and fixed response latency.
// Revision    : 1.0
// ============================================================================
module data_memory_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    data_memory_responder_if.slave bus
);
    localparam int          c_aw         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_depth      = 32'(DEPTH);
    localparam logic [3:0]  c_count_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic        c_lat_zero   = (LATENCY == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_count, w_count_next;
    logic        r_write;
    logic [29:0] r_word_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;
    logic [31:0] r_rdata;
    logic        r_error;
    logic        r_write_done;
    logic [31:0] r_mem [DEPTH];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_req_ready;
    logic             w_resp_valid;
    logic             w_acc_write;
    logic [29:0]      w_acc_word;
    logic [31:0]      w_acc_wdata;
    logic [3:0]       w_acc_mask;
    logic             w_acc_in_range;
    logic [c_aw-1:0]  w_acc_index;
    logic             w_mem_we;
    logic             w_unused_addr_lsb;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_count_next = c_count_init;
                    if (c_lat_zero) begin
                        w_state_next = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_count == 4'd0) begin
                    w_state_next = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // With zero latency the access happens on the accept edge, so use the live request.
    assign w_acc_write    = (r_state == IDLE) ? bus.req_write          : r_write;
    assign w_acc_word     = (r_state == IDLE) ? bus.req_address[31:2]  : r_word_addr;
    assign w_acc_wdata    = (r_state == IDLE) ? bus.req_write_data     : r_wdata;
    assign w_acc_mask     = (r_state == IDLE) ? bus.req_write_mask     : r_mask;
    assign w_acc_in_range = ({2'b00, w_acc_word} < c_depth);
    assign w_acc_index    = w_acc_word[c_aw-1:0];
    assign w_mem_we       = reset && w_enter_resp && w_acc_write && w_acc_in_range;
    assign w_unused_addr_lsb = ^bus.req_address[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_count      <= 4'd0;
            r_write      <= 1'b0;
            r_word_addr  <= 30'd0;
            r_wdata      <= 32'd0;
            r_mask       <= 4'd0;
            r_rdata      <= 32'd0;
            r_error      <= 1'b0;
            r_write_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_write_done <= 1'b0;
            if (w_accept) begin
                r_write     <= bus.req_write;
                r_word_addr <= bus.req_address[31:2];
                r_wdata     <= bus.req_write_data;
                r_mask      <= bus.req_write_mask;
            end
            if (w_enter_resp) begin
                r_error      <= !w_acc_in_range;
                r_write_done <= w_acc_write && w_acc_in_range;
                r_rdata      <= (!w_acc_write && w_acc_in_range) ? r_mem[w_acc_index] : 32'd0;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_mask[b]) begin
                    r_mem[w_acc_index][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready      = w_req_ready;
    assign bus.resp_valid     = w_resp_valid;
    assign bus.resp_read_data = r_rdata;
    assign bus.resp_error     = r_error;
    assign bus.write_done     = r_write_done;
endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_responder
// Description : Table-driven scoreboard bench for data_memory_responder.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_responder_if bus_a ();
    data_memory_responder_if bus_b ();

    data_memory_responder #(.DEPTH(1024), .LATENCY(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    data_memory_responder #(.DEPTH(16), .LATENCY(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_wd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask, input int hold, input logic [31:0] er,
                                input logic ee, input logic ew);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.mask = mask; v.hold = hold;
        v.exp_rdata = er; v.exp_err = ee; v.exp_wd = ew;
        return v;
    endfunction

    // One transaction on the LATENCY=2 instance; junk request traffic is driven while busy.
    task automatic run_a(input vec_t v);
        exp_t e;
        int   cyc;
        check("a_req_ready_idle", 32'(bus_a.req_ready), 32'd1);
        bus_a.req_valid      = 1'b1;
        bus_a.req_write      = v.wr;
        bus_a.req_address    = v.addr;
        bus_a.req_write_data = v.wdata;
        bus_a.req_write_mask = v.mask;
        bus_a.resp_ready     = (v.hold == 0);
        sb_q.push_back('{v.exp_rdata, v.exp_err, v.exp_wd});
        @(negedge clk);
        bus_a.req_write      = 1'b1;
        bus_a.req_address    = 32'h10;
        bus_a.req_write_data = 32'hBAD0BAD0;
        bus_a.req_write_mask = 4'hF;
        cyc = 1;
        while (!bus_a.resp_valid && cyc < 20) begin
            check("a_busy_req_ready", 32'(bus_a.req_ready), 32'd0);
            check("a_busy_write_done", 32'(bus_a.write_done), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check("a_latency", 32'(cyc), 32'd3);
        e = sb_q.pop_front();
        check("a_write_done", 32'(bus_a.write_done), 32'(e.wd));
        check("a_rdata", bus_a.resp_read_data, e.rdata);
        check("a_error", 32'(bus_a.resp_error), 32'(e.err));
        check("a_resp_req_ready", 32'(bus_a.req_ready), 32'd0);
        for (int i = 0; i < v.hold; i++) begin
            bus_a.req_address    = 32'h10 + 32'(i * 4);
            bus_a.req_write_data = 32'h0F0F0000 + 32'(i);
            @(negedge clk);
            check("hold_resp_valid", 32'(bus_a.resp_valid), 32'd1);
            check("hold_req_ready", 32'(bus_a.req_ready), 32'd0);
            check("hold_rdata", bus_a.resp_read_data, e.rdata);
            check("hold_error", 32'(bus_a.resp_error), 32'(e.err));
            check("hold_write_done", 32'(bus_a.write_done), 32'd0);
        end
        bus_a.req_valid  = 1'b0;
        bus_a.resp_ready = 1'b1;
        @(negedge clk);
        check("a_resp_released", 32'(bus_a.resp_valid), 32'd0);
        check("a_wd_after", 32'(bus_a.write_done), 32'd0);
    endtask

    vec_t vecs_a[16];
    vec_t vecs_b[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs_a[0]  = mk(1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0, 1'b1);
        vecs_a[1]  = mk(1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        vecs_a[2]  = mk(1'b1, 32'h10,  32'h000000AA, 4'h1, 0, 32'h0,        1'b0, 1'b1);
        vecs_a[3]  = mk(1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0, 1'b0);
        vecs_a[4]  = mk(1'b1, 32'h0,   32'h12345678, 4'hF, 0, 32'h0,        1'b0, 1'b1);
        vecs_a[5]  = mk(1'b0, 32'h1000,32'h0,        4'h0, 0, 32'h0,        1'b1, 1'b0);
        vecs_a[6]  = mk(1'b1, 32'h1000,32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1, 1'b0);
        vecs_a[7]  = mk(1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h12345678, 1'b0, 1'b0);
        vecs_a[8]  = mk(1'b1, 32'hFFC, 32'h00000000, 4'hF, 0, 32'h0,        1'b0, 1'b1);
        vecs_a[9]  = mk(1'b1, 32'hFFF, 32'h11223344, 4'hA, 0, 32'h0,        1'b0, 1'b1);
        vecs_a[10] = mk(1'b0, 32'hFFD, 32'h0,        4'h0, 0, 32'h11003300, 1'b0, 1'b0);
        vecs_a[11] = mk(1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0, 1'b1);
        vecs_a[12] = mk(1'b0, 32'h13,  32'h0,        4'h0, 5, 32'hDEADBEAA, 1'b0, 1'b0);
        vecs_a[13] = mk(1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0, 1'b0);
        vecs_a[14] = mk(1'b1, 32'h20,  32'h55555555, 4'hF, 0, 32'h0,        1'b0, 1'b1);
        vecs_a[15] = mk(1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0, 1'b0);

        vecs_b[0] = mk(1'b1, 32'h8,  32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0, 1'b1);
        vecs_b[1] = mk(1'b0, 32'h8,  32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
        vecs_b[2] = mk(1'b1, 32'hC,  32'h01020304, 4'hF, 0, 32'h0,        1'b0, 1'b1);
        vecs_b[3] = mk(1'b0, 32'hC,  32'h0,        4'h0, 0, 32'h01020304, 1'b0, 1'b0);
        vecs_b[4] = mk(1'b0, 32'h40, 32'h0,        4'h0, 0, 32'h0,        1'b1, 1'b0);

        reset = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_address = 32'h0;
        bus_a.req_write_data = 32'h0; bus_a.req_write_mask = 4'h0; bus_a.resp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_address = 32'h0;
        bus_b.req_write_data = 32'h0; bus_b.req_write_mask = 4'h0; bus_b.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
        check("rst_resp_error", 32'(bus_a.resp_error), 32'd0);
        check("rst_write_done", 32'(bus_a.write_done), 32'd0);
        check("rst_rdata", bus_a.resp_read_data, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(bus_a.req_ready), 32'd1);

        // Zero-latency instance: request valid held high, one accept every two cycles.
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            check("b_req_ready", 32'(bus_b.req_ready), 32'd1);
            check("b_idle_resp_valid", 32'(bus_b.resp_valid), 32'd0);
            bus_b.req_valid      = 1'b1;
            bus_b.req_write      = vecs_b[k].wr;
            bus_b.req_address    = vecs_b[k].addr;
            bus_b.req_write_data = vecs_b[k].wdata;
            bus_b.req_write_mask = vecs_b[k].mask;
            sb_q.push_back('{vecs_b[k].exp_rdata, vecs_b[k].exp_err, vecs_b[k].exp_wd});
            @(negedge clk);
            e = sb_q.pop_front();
            check("b_resp_valid", 32'(bus_b.resp_valid), 32'd1);
            check("b_resp_req_ready", 32'(bus_b.req_ready), 32'd0);
            check("b_rdata", bus_b.resp_read_data, e.rdata);
            check("b_error", 32'(bus_b.resp_error), 32'(e.err));
            check("b_write_done", 32'(bus_b.write_done), 32'(e.wd));
            @(negedge clk);
        end
        bus_b.req_valid = 1'b0;

        for (int k = 0; k < 15; k++) run_a(vecs_a[k]);

        // Abort a store to 0x20 while it is still waiting out its latency.
        bus_a.req_valid      = 1'b1;
        bus_a.req_write      = 1'b1;
        bus_a.req_address    = 32'h20;
        bus_a.req_write_data = 32'hAAAAAAAA;
        bus_a.req_write_mask = 4'hF;
        bus_a.resp_ready     = 1'b1;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        check("abort_busy_req_ready", 32'(bus_a.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_resp_valid", 32'(bus_a.resp_valid), 32'd0);
        check("abort_req_ready", 32'(bus_a.req_ready), 32'd1);
        check("abort_write_done", 32'(bus_a.write_done), 32'd0);
        check("abort_error", 32'(bus_a.resp_error), 32'd0);
        check("abort_rdata", bus_a.resp_read_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_resp", 32'(bus_a.resp_valid), 32'd0);
        run_a(mk(1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h55555555, 1'b0, 1'b0));
        run_a(vecs_a[15]);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
